// File: rtl/kogge_stone_adder_32bit.sv
`default_nettype none
// ============================================================================
// Module      : kogge_stone_adder_32bit
// Description : 32-bit Kogge-Stone parallel-prefix adder with carry-in/out,
//               combinational sum plus a one-cycle registered copy.
// Revision    : 1.0 - initial release
// ============================================================================
module kogge_stone_adder_32bit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  CIN,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  COUT,
    output logic [DATA_WIDTH-1:0] Y_q,
    output logic                  COUT_q
);

    localparam int LEVELS = $clog2(DATA_WIDTH);

    // Group-propagate terms are only needed for node i >= span at each level,
    // so they are packed back to back: level k holds DATA_WIDTH - 2^k bits.
    function automatic int p_off(input int lvl);
        return DATA_WIDTH * lvl - ((1 << lvl) - 1);
    endfunction

    localparam int c_p_bits = p_off(LEVELS);

    logic [DATA_WIDTH-1:0]             w_g;
    logic [DATA_WIDTH-1:0]             w_p;
    logic [LEVELS:0][DATA_WIDTH-1:0]   w_gl;
    logic [c_p_bits-1:0]               w_pp;
    logic [DATA_WIDTH-1:0]             w_carry;
    logic [DATA_WIDTH-1:0]             r_y_q;
    logic                              r_cout_q;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Carry-in folded into bit 0 so every later node covering bit 0 is a carry.
    assign w_gl[0] = {w_g[DATA_WIDTH-1:1], w_g[0] | (w_p[0] & CIN)};
    assign w_pp[DATA_WIDTH-2:0] = w_p[DATA_WIDTH-1:1];

    genvar k, i;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_level
            localparam int c_span = 1 << k;
            for (i = 0; i < DATA_WIDTH; i++) begin : g_bit
                if (i < c_span) begin : g_pass
                    assign w_gl[k+1][i] = w_gl[k][i];
                end else begin : g_cell
                    logic w_p_hi;
                    assign w_p_hi        = w_pp[p_off(k) + i - c_span];
                    assign w_gl[k+1][i]  = w_gl[k][i] | (w_p_hi & w_gl[k][i-c_span]);
                    // Lower node not yet reaching bit 0: black cell also merges P.
                    if ((i >= 2 * c_span) && (k < LEVELS - 1)) begin : g_black
                        assign w_pp[p_off(k+1) + i - 2*c_span] =
                            w_p_hi & w_pp[p_off(k) + i - 2*c_span];
                    end
                end
            end
        end
    endgenerate

    assign w_carry = {w_gl[LEVELS][DATA_WIDTH-2:0], CIN};
    assign Y       = w_p ^ w_carry;
    assign COUT    = w_gl[LEVELS][DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q    <= '0;
            r_cout_q <= 1'b0;
        end else begin
            r_y_q    <= Y;
            r_cout_q <= COUT;
        end
    end

    assign Y_q    = r_y_q;
    assign COUT_q = r_cout_q;

endmodule
`default_nettype wire

// File: tb/tb_kogge_stone_adder_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_kogge_stone_adder_32bit
// Description : Directed and random checks of the Kogge-Stone adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kogge_stone_adder_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] y;
    logic        cout;
    logic [31:0] y_q;
    logic        cout_q;

    int n_cmp;
    int n_err;

    kogge_stone_adder_32bit #(
        .DATA_WIDTH(32)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .CIN    (cin),
        .Y      (y),
        .COUT   (cout),
        .Y_q    (y_q),
        .COUT_q (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                             input logic vc, input logic [32:0] exp);
        a   = va;
        b   = vb;
        cin = vc;
        #1;
        check_val(tag, {cout, y}, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        cin   = 1'b0;

        // Registered path under reset, while the combinational sum keeps tracking.
        tick();
        tick();
        check_val("rst_q", {cout_q, y_q}, 33'h0_0000_0000);
        apply_vec("rst_comb", 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);
        tick();
        check_val("rst_hold_q", {cout_q, y_q}, 33'h0_0000_0000);

        rst_n = 1'b1;
        apply_vec("reg_in", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
        tick();
        check_val("reg_lat1", {cout_q, y_q}, 33'h1_0000_0000);
        apply_vec("reg_in2", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000);
        check_val("reg_hold", {cout_q, y_q}, 33'h1_0000_0000);
        tick();
        check_val("reg_lat2", {cout_q, y_q}, 33'h0_0001_0000);
        apply_vec("reg_in3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        rst_n = 1'b0;
        tick();
        check_val("mid_rst_q", {cout_q, y_q}, 33'h0_0000_0000);
        check_val("mid_rst_comb", {cout, y}, 33'h1_FFFF_FFFF);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_q", {cout_q, y_q}, 33'h1_FFFF_FFFF);

        apply_vec("zero",        32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
        apply_vec("ones_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
        apply_vec("full_prop",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        apply_vec("one_plus_m1", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 33'h1_0000_0000);
        apply_vec("cin_plus_m1", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 33'h1_0000_0000);
        apply_vec("mid_16",      32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000);
        apply_vec("mid_17",      32'h0001_FFFF, 32'h0001_0001, 1'b0, 33'h0_0003_0000);
        apply_vec("bit30",       32'h4000_0000, 32'h4000_0000, 1'b0, 33'h0_8000_0000);
        apply_vec("double",      32'h0CF9_8D40, 32'h0CF9_8D40, 1'b0, 33'h0_19F3_1A80);
        apply_vec("s_5_m3",      32'h0000_0005, 32'hFFFF_FFFD, 1'b0, 33'h1_0000_0002);
        apply_vec("s_m5_m3",     32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b0, 33'h1_FFFF_FFF8);
        apply_vec("s_max_1",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
        apply_vec("mixed_cin",   32'h1234_5678, 32'h8765_4321, 1'b1, 33'h0_9999_999A);
        apply_vec("alt_bits",    32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF);
        apply_vec("alt_bits_c",  32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
        apply_vec("top_carry",   32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001);

        for (int n = 0; n < 10000; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            logic [32:0] ref_sum;
            ra      = $urandom;
            rb      = $urandom;
            rc      = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            apply_vec("rand", ra, rb, rc, ref_sum);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
